iq_comp: RTL and testbench
==========================

# iq_comp

Receiver-side blind IQ-imbalance compensator between the 4-bit I/Q ADC samplers and the demodulator. It computes y = x + W·conj(x) on each complex sample x = I + jQ. The complex weight W = Wr + jWj adapts by sign-LMS-free blind update W ← W − µ·y², can be frozen, or can be forced from external inputs. It reports the live weights and a settled flag.

## Interface
- W_FRAC, 12: fractional bits of Wr/Wj (Q1.12; 4096 = 1.0).
- MU_SHIFT, 0: update step; delta = error <<< MU_SHIFT.
- SETTLE_THRESH, 1: max |delta| counted as "small".
- SETTLE_CNT, 64: consecutive small updates required for settled.
- clk  input  1  sample clock, one sample per rising edge.
- RESETn  input  1  one clock; reset is synchronous and active-high (asserted when 1; port name kept per codebase convention).
- freeze_iqcomp  input  1  1 = hold W (no adaptation).
- op_mode  input  2  00 bypass, 01 adaptive, 10 fixed external weights, 11 reserved (= bypass).
- Ix, Qx  input  4  unsigned offset-binary samples (8 = zero).
- Wr_in, Wj_in  input  13  signed external weights used in mode 10.
- Iy, Qy  output  4  signed two's-complement compensated samples.
- settled  output  1  adaptation converged.
- Wr, Wj  output  13  signed current weight register.

## Operation
- Input conversion: I = Ix − 8, Q = Qx − 8, signed range [−8, 7].
- Weight source We: Wr_in/Wj_in in mode 10; otherwise the internal W register.
- Products are 13×4 signed, summed to 18 bits:
  - yI = I + ((We_r·I + We_j·Q) >>> W_FRAC)
  - yQ = Q + ((We_j·I − We_r·Q) >>> W_FRAC)
  - The shift is arithmetic, so it rounds toward −∞.
  - Each result saturates to [−8, 7].
- Bypass (00/11): yI = I, yQ = Q. W register holds its value.
- Adaptive (01), freeze = 0:
  - er = yI² − yQ², ej = 2·yI·yQ.
  - dr = er <<< MU_SHIFT, dj = ej <<< MU_SHIFT.
  - Wr ← sat13(Wr − dr), Wj ← sat13(Wj − dj), saturating to [−4096, 4095].
- Adaptive, freeze = 1: W held; outputs remain compensated with the held W.
- Fixed (10): W register ← Wr_in/Wj_in every cycle.
- Settle detector (mode 01 only):
  - Counter increments when |dr| ≤ SETTLE_THRESH and |dj| ≤ SETTLE_THRESH.
  - Counter clears to 0 on any larger update.
  - Counter saturates at SETTLE_CNT; settled = (counter == SETTLE_CNT).
  - freeze = 1 holds both counter and settled.
  - In any mode other than 01: counter = 0 and settled = 0.

## Timing
- All outputs are registered.
- Iy/Qy present the compensation of the Ix/Qx sampled at the previous edge (latency 1 cycle).
- W update uses the y computed from the same sample and the pre-edge W. The new W affects the next sample.
- Wr/Wj outputs are the W register directly.
  - In mode 10 they equal Wr_in/Wj_in one cycle late.
  - The datapath uses Wr_in/Wj_in combinationally, with no lag.
- op_mode or freeze changes take effect on the next edge; no pipeline flush is required.
- Reset (RESETn = 1 at an edge) overrides everything, including mid-adaptation:
  - Iy = Qy = 0, Wr = Wj = 0, settled = 0, counter = 0.

## Configuration
- IQCOMP_SETTLE_EN defined: settle detector and counter are implemented as above.
- IQCOMP_SETTLE_EN undefined:
  - No counter logic.
  - settled is tied to 0.
  - Other behaviour is identical.

## Test plan
- Reset: RESETn = 1 for 8 cycles with random Ix/Qx → Iy = Qy = 0, Wr = Wj = 0, settled = 0 throughout.
- Bypass: op_mode = 00, Ix = 4'hC, Qx = 4'h3 → next cycle Iy = 4, Qy = −5; Wr/Wj unchanged.
- Fixed weights: op_mode = 10, Wr_in = 2048, Wj_in = 0.
  - Ix = 4'hC, Qx = 4'h8 → Iy = 6, Qy = 0, and Wr = 2048 one cycle later.
  - Ix = 4'hF → Iy saturates to 7.
- Adaptation: from reset, op_mode = 01, Ix = 4'hB, Qx = 4'h8 held.
  - Cycle 1: Iy = 3, Wr = −9.
  - Cycle 2: Iy = 2, Wr = −13.
  - Wj stays 0 throughout.
- Freeze: adapting as above, then freeze_iqcomp = 1 for 10 cycles → Wr/Wj constant and Iy/Qy still compensated. Release → adaptation resumes next edge.
- Settle:
  - op_mode = 01 with Ix = Qx = 8 → settled = 1 after 64 cycles.
  - Then one sample Ix = 4'hF, Qx = 8 → settled = 0 the following cycle.
  - Switching to op_mode = 00 also clears settled.

Source files
------------

// File: rtl/iq_comp.sv
// iq_comp: receiver-side blind IQ-imbalance compensator.
// Computes y = x + W*conj(x) on each offset-binary I/Q sample and adapts W
// blindly (W <- W - mu*y^2), can freeze W, or load it from Wr_in/Wj_in.
// Optional feature macro: IQCOMP_SETTLE_EN builds the settle detector;
// without it the settled output is tied to 0.
//
// Data flow: one sample per rising edge, no handshake. Ix/Qx are sampled at
// every edge; Iy/Qy and Wr/Wj are registered and show the result one edge
// later. There is no back-pressure and no valid qualifier.
module iq_comp #(
  parameter int W_FRAC        = 12,
  parameter int MU_SHIFT      = 0,
  parameter int SETTLE_THRESH = 1,
  parameter int SETTLE_CNT    = 64
) (
  input  logic               clk,
  input  logic               RESETn,
  input  logic               freeze_iqcomp,
  input  logic [1:0]         op_mode,
  input  logic [3:0]         Ix,
  input  logic [3:0]         Qx,
  input  logic signed [12:0] Wr_in,
  input  logic signed [12:0] Wj_in,
  output logic signed [3:0]  Iy,
  output logic signed [3:0]  Qy,
  output logic               settled,
  output logic signed [12:0] Wr,
  output logic signed [12:0] Wj
);

  localparam logic [1:0] MODE_ADAPT = 2'b01;
  localparam logic [1:0] MODE_FIXED = 2'b10;

  // Clamp an 18-bit signed sum to the 4-bit output range [-8, 7].
  function automatic logic signed [3:0] sat4(input logic signed [17:0] v);
    if (v > 18'sd7)       return 4'sb0111;
    else if (v < -18'sd8) return 4'sb1000;
    else                  return v[3:0];
  endfunction

  // Clamp a 32-bit signed value to the 13-bit weight range [-4096, 4095].
  function automatic logic signed [12:0] sat13(input logic signed [31:0] v);
    if (v > 32'sd4095)       return 13'sb0_1111_1111_1111;
    else if (v < -32'sd4096) return 13'sb1_0000_0000_0000;
    else                     return v[12:0];
  endfunction

  // Offset-binary to two's complement: subtracting 8 just flips the MSB.
  logic signed [3:0] i_s, q_s;
  assign i_s = {~Ix[3], Ix[2:0]};
  assign q_s = {~Qx[3], Qx[2:0]};

  // Fixed mode feeds the external weights straight into the datapath.
  logic signed [12:0] we_r, we_j;
  assign we_r = (op_mode == MODE_FIXED) ? Wr_in : Wr;
  assign we_j = (op_mode == MODE_FIXED) ? Wj_in : Wj;

  // 13x4 signed products, summed to 18 bits.
  logic signed [16:0] p_ri, p_jq, p_ji, p_rq;
  assign p_ri = 17'(we_r) * 17'(i_s);
  assign p_jq = 17'(we_j) * 17'(q_s);
  assign p_ji = 17'(we_j) * 17'(i_s);
  assign p_rq = 17'(we_r) * 17'(q_s);

  logic signed [17:0] acc_i, acc_q, sh_i, sh_q, tot_i, tot_q;
  assign acc_i = 18'(p_ri) + 18'(p_jq);
  assign acc_q = 18'(p_ji) - 18'(p_rq);
  // Arithmetic shift: the correction term rounds toward minus infinity.
  assign sh_i  = acc_i >>> W_FRAC;
  assign sh_q  = acc_q >>> W_FRAC;
  assign tot_i = 18'(i_s) + sh_i;
  assign tot_q = 18'(q_s) + sh_q;

  // Bypass (00 and the reserved 11) passes the converted sample untouched.
  logic bypass;
  logic signed [3:0] y_i, y_q;
  assign bypass = (op_mode != MODE_ADAPT) && (op_mode != MODE_FIXED);
  assign y_i    = bypass ? i_s : sat4(tot_i);
  assign y_q    = bypass ? q_s : sat4(tot_q);

  // Blind error y^2 = (yI^2 - yQ^2) + j(2 yI yQ), scaled by the step size.
  logic signed [9:0]  yi_w, yq_w, er, ej;
  logic signed [31:0] dr, dj;
  logic signed [12:0] wr_upd, wj_upd;
  assign yi_w   = 10'(y_i);
  assign yq_w   = 10'(y_q);
  assign er     = (yi_w * yi_w) - (yq_w * yq_w);
  assign ej     = (yi_w * yq_w) <<< 1;
  assign dr     = 32'(er) <<< MU_SHIFT;
  assign dj     = 32'(ej) <<< MU_SHIFT;
  assign wr_upd = sat13(32'(Wr) - dr);
  assign wj_upd = sat13(32'(Wj) - dj);

  // Output sample register and weight register (adapt, load, or hold).
  always_ff @(posedge clk) begin
    if (RESETn) begin
      Iy <= '0;
      Qy <= '0;
      Wr <= '0;
      Wj <= '0;
    end else begin
      Iy <= y_i;
      Qy <= y_q;
      case (op_mode)
        MODE_FIXED: begin
          Wr <= Wr_in;
          Wj <= Wj_in;
        end
        MODE_ADAPT: begin
          if (!freeze_iqcomp) begin
            Wr <= wr_upd;
            Wj <= wj_upd;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IQCOMP_SETTLE_EN
  localparam int CW = $clog2(SETTLE_CNT + 1);

  logic [CW-1:0]      cnt, cnt_nxt;
  logic signed [31:0] abs_dr, abs_dj;
  logic               small;
  assign abs_dr = (dr < 0) ? -dr : dr;
  assign abs_dj = (dj < 0) ? -dj : dj;
  assign small  = (abs_dr <= 32'(SETTLE_THRESH)) && (abs_dj <= 32'(SETTLE_THRESH));

  // Next count of consecutive small updates; only live in adaptive mode.
  always_comb begin
    cnt_nxt = cnt;
    if (op_mode != MODE_ADAPT)        cnt_nxt = '0;
    else if (freeze_iqcomp)           cnt_nxt = cnt;
    else if (!small)                  cnt_nxt = '0;
    else if (cnt != CW'(SETTLE_CNT))  cnt_nxt = cnt + CW'(1);
  end

  // Settle counter and registered settled flag.
  always_ff @(posedge clk) begin
    if (RESETn) begin
      cnt     <= '0;
      settled <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      settled <= (cnt_nxt == CW'(SETTLE_CNT));
    end
  end
`else
  assign settled = 1'b0;
`endif

endmodule

// File: tb/tb_iq_comp.sv
// tb_iq_comp: directed and randomized checks of iq_comp against an
// arithmetic reference model (floor division, clamps, plain integers).
module tb_iq_comp;

  localparam int W_ONE    = 4096;
  localparam int MU_SCALE = 1;
  localparam int S_THRESH = 1;
  localparam int S_CNT    = 64;
`ifdef IQCOMP_SETTLE_EN
  localparam logic SET_EN = 1'b1;
`else
  localparam logic SET_EN = 1'b0;
`endif

  logic               clk;
  logic               RESETn;
  logic               freeze_iqcomp;
  logic [1:0]         op_mode;
  logic [3:0]         Ix, Qx;
  logic signed [12:0] Wr_in, Wj_in;
  logic signed [3:0]  iy, qy;
  logic               settled;
  logic signed [12:0] wr, wj;

  iq_comp dut (
    .clk           (clk),
    .RESETn        (RESETn),
    .freeze_iqcomp (freeze_iqcomp),
    .op_mode       (op_mode),
    .Ix            (Ix),
    .Qx            (Qx),
    .Wr_in         (Wr_in),
    .Wj_in         (Wj_in),
    .Iy            (iy),
    .Qy            (qy),
    .settled       (settled),
    .Wr            (wr),
    .Wj            (wj)
  );

  // Clock / reset block: reset itself is driven as part of each step.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: packed {Iy, Qy, Wr, Wj, settled} expected after each edge.
  logic [34:0] exp_q[$];

  // Reference model state.
  int m_wr = 0, m_wj = 0, m_cnt = 0;
  logic m_set = 1'b0;

  function automatic int fdiv(input int a);
    if (a >= 0) return a / W_ONE;
    else        return -((-a + W_ONE - 1) / W_ONE);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One sample of the specified behaviour, using pre-edge weights.
  task automatic model_step(input logic rst_v, input logic [1:0] md,
                            input logic frz, input logic [3:0] ix,
                            input logic [3:0] qx, input int wri, input int wji,
                            output logic [34:0] e);
    int i, q, wer, wej, yi, yq, dr, dj;
    if (rst_v) begin
      m_wr = 0; m_wj = 0; m_cnt = 0; m_set = 1'b0;
      e = '0;
      return;
    end
    i = int'(ix) - 8;
    q = int'(qx) - 8;
    wer = (md == 2'b10) ? wri : m_wr;
    wej = (md == 2'b10) ? wji : m_wj;
    if (md == 2'b01 || md == 2'b10) begin
      yi = clamp(i + fdiv(wer * i + wej * q), -8, 7);
      yq = clamp(q + fdiv(wej * i - wer * q), -8, 7);
    end else begin
      yi = i;
      yq = q;
    end
    dr = (yi * yi - yq * yq) * MU_SCALE;
    dj = 2 * yi * yq * MU_SCALE;
    if (md == 2'b01 && !frz) begin
      m_wr = clamp(m_wr - dr, -4096, 4095);
      m_wj = clamp(m_wj - dj, -4096, 4095);
    end else if (md == 2'b10) begin
      m_wr = wri;
      m_wj = wji;
    end
    if (md != 2'b01) m_cnt = 0;
    else if (!frz) begin
      if (iabs(dr) <= S_THRESH && iabs(dj) <= S_THRESH)
        m_cnt = (m_cnt < S_CNT) ? m_cnt + 1 : S_CNT;
      else
        m_cnt = 0;
    end
    m_set = SET_EN && (m_cnt == S_CNT);
    e = {4'(yi), 4'(yq), 13'(m_wr), 13'(m_wj), m_set};
  endtask

  task automatic check_sb();
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_iy",      iy,      $signed(e[34:31]));
    chk("sb_qy",      qy,      $signed(e[30:27]));
    chk("sb_wr",      wr,      $signed(e[26:14]));
    chk("sb_wj",      wj,      $signed(e[13:1]));
    chk("sb_settled", settled, {31'b0, e[0]});
  endtask

  // Driver: apply one sample, advance one edge, check just after it.
  task automatic cycle(input logic rst_v, input logic [1:0] md, input logic frz,
                       input logic [3:0] ix, input logic [3:0] qx,
                       input int wri, input int wji);
    logic [34:0] e;
    RESETn        = rst_v;
    op_mode       = md;
    freeze_iqcomp = frz;
    Ix            = ix;
    Qx            = qx;
    Wr_in         = 13'(wri);
    Wj_in         = 13'(wji);
    model_step(rst_v, md, frz, ix, qx, wri, wji, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  initial begin
    RESETn = 1'b1; freeze_iqcomp = 1'b0; op_mode = 2'b00;
    Ix = 4'h8; Qx = 4'h8; Wr_in = '0; Wj_in = '0;

    // Reset with random samples.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1000, -700);
      chk("rst_iy", iy, 0);
      chk("rst_wr", wr, 0);
      chk("rst_settled", settled, 0);
    end

    // Bypass.
    cycle(1'b0, 2'b00, 1'b0, 4'hC, 4'h3, 0, 0);
    chk("byp_iy", iy, 4);
    chk("byp_qy", qy, -5);
    chk("byp_wr", wr, 0);
    chk("byp_wj", wj, 0);

    // Fixed external weights.
    cycle(1'b0, 2'b10, 1'b0, 4'hC, 4'h8, 2048, 0);
    chk("fix_iy", iy, 6);
    chk("fix_qy", qy, 0);
    chk("fix_wr", wr, 2048);
    cycle(1'b0, 2'b10, 1'b0, 4'hF, 4'h8, 2048, 0);
    chk("fix_sat_iy", iy, 7);

    // Adaptation from reset.
    cycle(1'b1, 2'b01, 1'b0, 4'hB, 4'h8, 0, 0);
    cycle(1'b0, 2'b01, 1'b0, 4'hB, 4'h8, 0, 0);
    chk("ad1_iy", iy, 3);
    chk("ad1_wr", wr, -9);
    cycle(1'b0, 2'b01, 1'b0, 4'hB, 4'h8, 0, 0);
    chk("ad2_iy", iy, 2);
    chk("ad2_wr", wr, -13);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 2'b01, 1'b0, 4'hB, 4'h8, 0, 0);
      chk("ad_wj", wj, 0);
    end
    chk("ad5_wr", wr, -25);

    // Freeze holds W, output stays compensated.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 2'b01, 1'b1, 4'hB, 4'h8, 0, 0);
      chk("frz_wr", wr, -25);
      chk("frz_iy", iy, 2);
    end
    cycle(1'b0, 2'b01, 1'b0, 4'hB, 4'h8, 0, 0);
    chk("unfrz_wr", wr, -29);

    // Settle detector.
    cycle(1'b1, 2'b01, 1'b0, 4'h8, 4'h8, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      cycle(1'b0, 2'b01, 1'b0, 4'h8, 4'h8, 0, 0);
      if (k == 63) chk("set_63", settled, 0);
    end
    chk("set_64", settled, SET_EN);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 2'b01, 1'b1, 4'hF, 4'h8, 0, 0);
      chk("set_frz_hold", settled, SET_EN);
    end
    cycle(1'b0, 2'b01, 1'b0, 4'hF, 4'h8, 0, 0);
    chk("set_clr_big", settled, 0);
    chk("set_big_wr", wr, -49);
    for (int k = 0; k < 64; k++)
      cycle(1'b0, 2'b01, 1'b0, 4'h8, 4'h8, 0, 0);
    chk("set_again", settled, SET_EN);
    cycle(1'b0, 2'b00, 1'b0, 4'h8, 4'h8, 0, 0);
    chk("set_clr_mode", settled, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [1:0] md;
      int sel;
      sel = int'($urandom_range(0, 9));
      md  = (sel < 6) ? 2'b01 : 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 49) == 0), md, ($urandom_range(0, 4) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 8191)) - 4096,
            int'($urandom_range(0, 8191)) - 4096);
    end

    // Long quiet stretch after random weights.
    for (int k = 0; k < 80; k++)
      cycle(1'b0, 2'b01, 1'b0, 4'h8, 4'h8, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
